uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter, the transmit-side counterpart of the team's UART receiver. It accepts a parallel word over a valid/ready handshake and shifts out one frame on `tx`: a start bit, then DATA_SIZE data bits LSB-first, an optional parity bit, and one stop bit. Bit timing comes from an internal clock divider. The block sits between the system-side producer (CPU register or FIFO) and the serial pin, and it loops back cleanly into the receiver for self-test.

## Interface
- `CLK_DIV`, default 10: clk cycles per bit (clk/baud); legal range ≥2.
- `DATA_SIZE`, default 8: data bits per frame; legal range 5..10.
- `PARITY_EN`, default 1: 1 inserts a parity bit after the data bits; 0 omits it.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low; clock `clk`.
- `tx_valid`  in  1  producer has a word on `tx_data`.
- `tx_data`  in  DATA_SIZE  word to send; sampled only on acceptance.
- `tx_ready`  out  1  block can accept a word (high only in IDLE).
- `busy`  out  1  high from the acceptance cycle through the end of the stop bit.
- `tx`  out  1  serial line; idles high.
- `done`  out  1  one-cycle pulse when the stop bit completes.

## Operation
- Reset values (reset=0 at a clk edge): `tx`=1, `tx_ready`=1, `busy`=0, `done`=0; state=IDLE; bit counter, baud counter and shift register all 0.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when `tx_valid && tx_ready`.
  - START → DATA after 1 bit time.
  - DATA → PARITY (PARITY_EN=1) or STOP (PARITY_EN=0) after DATA_SIZE bit times.
  - PARITY → STOP after 1 bit time.
  - STOP → IDLE after 1 bit time.
- Acceptance: in the acceptance cycle, latch `tx_data` into the shift register and compute parity. Parity = XOR of all data bits, inverted when PARITY_ODD=1. Clear the baud counter.
- Bit time: the baud counter counts 0..CLK_DIV-1 and runs only outside IDLE. A bit boundary (`tick`) occurs at count CLK_DIV-1. Each bit is exactly CLK_DIV cycles; there is no drift and no half-bit phase.
- DATA: `tx` = shift_reg[0]; the register shifts right on each tick. The bit counter counts 0..DATA_SIZE-1 and is cleared on leaving DATA.
- `tx` is registered: it is 0 in START, the current data bit in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
- `tx_data` changes after acceptance have no effect on the frame in flight.
- `tx_valid` while busy: ignored (`tx_ready`=0). The producer holds the word until accepted.
- Reset mid-frame: the frame is aborted. The next edge after reset deasserts leaves `tx`=1 and state IDLE. No `done` pulse is produced for the aborted frame.
- Illegal state encoding: go to IDLE with `tx`=1.

## Timing
- Word accepted at edge k (`tx_valid`=1, `tx_ready`=1): `busy`=1 and `tx`=0 from k+1.
- Frame length F = (2 + DATA_SIZE + PARITY_EN) × CLK_DIV cycles, counted from k+1.
- `done` is high for exactly the one cycle starting at k+1+F, the same cycle that `tx_ready` returns to 1 and `busy` returns to 0.
- Back-to-back: if `tx_valid` is held, the next word is accepted in the `done` cycle, and its start bit begins one cycle later. The effective stop bit is therefore CLK_DIV+1 cycles, and the minimum frame period is F+1.
- There is no combinational path from inputs to outputs. `tx_ready` is a decode of registered state only.

## Structure
- Shared header `uart_defs.vh`, also used by the receiver:
  - state encodings (IDLE=3'b000, START=3'b001, DATA=3'b010, STOP=3'b011, PARITY=3'b100);
  - the default CLK_DIV and DATA_SIZE;
  - the parity-mode constants.
- One sub-module: `uart_baud_gen`, a divider with an enable and a synchronous clear. It outputs `tick` at count CLK_DIV-1. The receiver can reuse it.
- The FSM, shift register, parity and bit counter stay in `uart_tx`.

## Test plan
- Reset: hold reset=0 for 3 cycles while `tx_valid`=1. Required: `tx`=1, `tx_ready`=1, `busy`=0, `done`=0 throughout, and no frame starts.
- Single frame (CLK_DIV=10, DATA_SIZE=8, even parity), send 8'hA5. Required line sequence, each bit held 10 cycles: 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1. Total 110 cycles; `done` pulses at cycle 111 after acceptance.
- Odd parity with PARITY_ODD=1, send 8'h01. Required parity bit = 0. With PARITY_EN=0, the frame is 100 cycles and no parity bit appears.
- Back-to-back: hold `tx_valid` with 8'h55 then 8'hFF. Required:
  - the second start bit begins 1 cycle after the first frame's `done`;
  - `tx_data` changes during the first frame do not corrupt it.
- Reset mid-frame: assert reset during data bit 3. Required: `tx`=1 on the next edge, no `done` pulse, and the next accepted word 8'h3C is transmitted correctly.
- Loopback into the UART receiver, 256 words 8'h00..8'hFF. Required: every received data word and parity bit matches what was sent.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: state encodings, default frame geometry and parity modes.
// Imported by the transmitter and by the matching receiver.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b000,
      ST_START  = 3'b001,
      ST_DATA   = 3'b010,
      ST_STOP   = 3'b011,
      ST_PARITY = 3'b100
   } uart_state_t;

   localparam int DEF_CLK_DIV   = 10;
   localparam int DEF_DATA_SIZE = 8;

   localparam logic PARITY_MODE_EVEN = 1'b0;
   localparam logic PARITY_MODE_ODD  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time divider: counts 0..CLK_DIV-1 while enabled and flags the last count.
// Held at zero when disabled or cleared, so every bit starts on a fresh count.
module uart_baud_gen
   import uart_tx_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_clr || !i_en) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST_CNT) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = i_en && (r_cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word intake, start + LSB-first data + optional parity + stop.
// All outputs come from registers or a decode of the registered state.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int DATA_SIZE  = DEF_DATA_SIZE,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_valid,
   input  logic [DATA_SIZE-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 busy,
   output logic                 tx,
   output logic                 done
);

   localparam int BW = $clog2(DATA_SIZE);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_SIZE - 1);
   localparam logic ODD_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

   uart_state_t          r_state, w_state_next;
   logic [DATA_SIZE-1:0] r_shift, w_shift_next;
   logic [BW-1:0]        r_bit_cnt, w_bit_cnt_next;
   logic                 r_parity, w_parity_next;
   logic                 r_tx, w_tx_next;
   logic                 r_done, w_done_next;
   logic                 w_idle, w_accept, w_tick;

   assign w_idle   = (r_state == ST_IDLE);
   assign w_accept = tx_valid && w_idle;

   uart_baud_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_baud (
      .clk    (clk),
      .reset  (reset),
      .i_en   (!w_idle),
      .i_clr  (w_accept),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_shift   <= w_shift_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_parity  <= w_parity_next;
         r_tx      <= w_tx_next;
         r_done    <= w_done_next;
      end
   end

   // tx is loaded with the value of the bit that the next state will drive
   always_comb begin
      w_state_next   = r_state;
      w_shift_next   = r_shift;
      w_bit_cnt_next = r_bit_cnt;
      w_parity_next  = r_parity;
      w_tx_next      = r_tx;
      w_done_next    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_tx_next = 1'b1;
            if (w_accept) begin
               w_state_next  = ST_START;
               w_shift_next  = tx_data;
               w_parity_next = (^tx_data) ^ ODD_MODE;
               w_tx_next     = 1'b0;
            end
         end
         ST_START: begin
            if (w_tick) begin
               w_state_next = ST_DATA;
               w_tx_next    = r_shift[0];
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               w_shift_next = r_shift >> 1;
               if (r_bit_cnt == LAST_BIT) begin
                  w_bit_cnt_next = '0;
                  if (PARITY_EN != 0) begin
                     w_state_next = ST_PARITY;
                     w_tx_next    = r_parity;
                  end else begin
                     w_state_next = ST_STOP;
                     w_tx_next    = 1'b1;
                  end
               end else begin
                  w_bit_cnt_next = r_bit_cnt + 1'b1;
                  w_tx_next      = r_shift[1];
               end
            end
         end
         ST_PARITY: begin
            if (w_tick) begin
               w_state_next = ST_STOP;
               w_tx_next    = 1'b1;
            end
         end
         ST_STOP: begin
            if (w_tick) begin
               w_state_next = ST_IDLE;
               w_tx_next    = 1'b1;
               w_done_next  = 1'b1;
            end
         end
         default: begin
            w_state_next   = ST_IDLE;
            w_bit_cnt_next = '0;
            w_tx_next      = 1'b1;
         end
      endcase
   end

   assign tx_ready = w_idle;
   assign busy     = !w_idle;
   assign tx       = r_tx;
   assign done     = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (even parity, odd parity, no parity) checked
// cycle by cycle against a frame model built from the framing rules, plus a loopback decode.
module tb_uart_tx;

   localparam int DIV = 10;
   localparam int DS  = 8;
   localparam bit [2:0] PEN_TAB = 3'b011;
   localparam bit [2:0] POD_TAB = 3'b010;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] tx_valid = 3'b000;
   logic [7:0] tx_data [3];
   wire  [2:0] tx_ready, busy, tx, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         uart_tx #(
            .CLK_DIV   (DIV),
            .DATA_SIZE (DS),
            .PARITY_EN (int'(PEN_TAB[gi])),
            .PARITY_ODD(int'(POD_TAB[gi]))
         ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .tx_valid (tx_valid[gi]),
            .tx_data  (tx_data[gi]),
            .tx_ready (tx_ready[gi]),
            .busy     (busy[gi]),
            .tx       (tx[gi]),
            .done     (done[gi])
         );
      end
   endgenerate

   function automatic int frame_len(int u);
      return (2 + DS + int'(PEN_TAB[u])) * DIV;
   endfunction

   // Line level of bit slot idx: start, data LSB first, optional parity, then stop.
   function automatic logic frame_bit(int u, logic [7:0] d, int idx);
      if (idx == 0) return 1'b0;
      if (idx <= DS) return d[idx-1];
      if (PEN_TAB[u] && idx == DS + 1) return logic'(($countones(d) % 2) != 0) ^ POD_TAB[u];
      return 1'b1;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Entered at the negedge of the acceptance cycle with tx_valid/tx_data driven;
   // returns at the negedge of the done cycle.
   task automatic run_frame(int u, logic [7:0] d, bit hold, logic [7:0] scribble);
      int f;
      f = frame_len(u);
      chk("accept_ready", 32'(tx_ready[u]), 32'd1);
      @(negedge clk);
      if (!hold) tx_valid[u] = 1'b0;
      tx_data[u] = scribble;
      for (int c = 0; c < f; c++) begin
         if (c > 0) @(negedge clk);
         chk("frame_line", {tx[u], busy[u], done[u], tx_ready[u]},
             {frame_bit(u, d, c / DIV), 3'b100});
      end
      @(negedge clk);
      chk("done_cycle", {tx[u], busy[u], done[u], tx_ready[u]}, 32'b1011);
      $display("frame unit=%0d data=%h cycles=%0d", u, d, f);
   endtask

   initial begin
      logic [7:0] d;
      for (int u = 0; u < 3; u++) tx_data[u] = 8'h00;

      // reset held low with valid asserted: nothing may start
      tx_valid = 3'b111;
      repeat (3) begin
         @(negedge clk);
         chk("reset_idle", {tx, busy, done, tx_ready}, {3'b111, 3'b000, 3'b000, 3'b111});
      end
      reset    = 1'b1;
      tx_valid = 3'b000;
      @(negedge clk);
      chk("post_reset_idle", {tx, busy, done, tx_ready}, {3'b111, 3'b000, 3'b000, 3'b111});

      // directed words, then random words, on every configuration
      for (int u = 0; u < 3; u++) begin
         d = (u == 0) ? 8'hA5 : 8'h01;
         tx_valid[u] = 1'b1;
         tx_data[u]  = d;
         run_frame(u, d, 1'b0, 8'($urandom));
         @(negedge clk);
         chk("done_one_cycle", 32'(done[u]), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         for (int u = 0; u < 3; u++) begin
            d = 8'($urandom);
            tx_valid[u] = 1'b1;
            tx_data[u]  = d;
            run_frame(u, d, 1'b0, 8'($urandom));
            @(negedge clk);
            chk("done_one_cycle", 32'(done[u]), 32'd0);
         end
      end

      // back-to-back with the data bus changing during the first frame
      tx_valid[0] = 1'b1;
      tx_data[0]  = 8'h55;
      run_frame(0, 8'h55, 1'b1, 8'hFF);
      run_frame(0, 8'hFF, 1'b0, 8'($urandom));
      @(negedge clk);
      chk("b2b_done_end", 32'(done[0]), 32'd0);

      // reset during data bit 3 aborts the frame
      d = 8'($urandom);
      tx_valid[0] = 1'b1;
      tx_data[0]  = d;
      chk("abort_accept_ready", 32'(tx_ready[0]), 32'd1);
      @(negedge clk);
      tx_valid[0] = 1'b0;
      repeat (44) @(negedge clk);
      chk("abort_in_bit3", 32'(tx[0]), 32'(d[3]));
      reset = 1'b0;
      @(negedge clk);
      chk("abort_line", {tx[0], busy[0], done[0]}, 32'b100);
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("abort_idle", {tx[0], busy[0], done[0], tx_ready[0]}, 32'b1001);
      end
      tx_valid[0] = 1'b1;
      tx_data[0]  = 8'h3C;
      run_frame(0, 8'h3C, 1'b0, 8'($urandom));
      @(negedge clk);
      chk("abort_recover_done_end", 32'(done[0]), 32'd0);

      // loopback: streaming producer and a mid-bit sampling receiver
      fork
         begin : producer
            int t;
            tx_valid[0] = 1'b1;
            for (int i = 0; i < 256; i++) begin
               tx_data[0] = 8'(i);
               t = 0;
               while (!tx_ready[0] && t < 400) begin
                  @(negedge clk);
                  t++;
               end
               if (t >= 400) begin
                  chk("tx_producer_timeout", 32'(t), 32'd0);
                  break;
               end
               @(negedge clk);
            end
            tx_valid[0] = 1'b0;
         end
         begin : receiver
            int t;
            logic [7:0] w;
            logic p, s;
            for (int i = 0; i < 256; i++) begin
               t = 0;
               while (tx[0] !== 1'b0 && t < 400) begin
                  @(negedge clk);
                  t++;
               end
               if (t >= 400) begin
                  chk("rx_start_timeout", 32'(t), 32'd0);
                  break;
               end
               repeat (DIV / 2) @(negedge clk);
               for (int b = 0; b < DS; b++) begin
                  repeat (DIV) @(negedge clk);
                  w[b] = tx[0];
               end
               repeat (DIV) @(negedge clk);
               p = tx[0];
               repeat (DIV) @(negedge clk);
               s = tx[0];
               chk("rx_data", 32'(w), 32'(i));
               chk("rx_parity", 32'(p), 32'(($countones(8'(i)) % 2) != 0));
               chk("rx_stop", 32'(s), 32'd1);
               $display("loopback word=%h rx=%h parity=%0b", 8'(i), w, p);
            end
         end
      join

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
